// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers feed the right column of a shifting 3x3 window.
module conv_window_3x3 #(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10,
  parameter int DATA_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_vsync,
  input  logic                pix_href,
  input  logic [DATA_W-1:0]   pix_data,
  output logic                matrix_vsync,
  output logic                matrix_href,
  output logic [6:0]          matrix_h_cnt,
  output logic [6:0]          matrix_v_cnt,
  output logic [9*DATA_W-1:0] fm_data,
  output logic                frame_err
);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int CW = 3 * DATA_W;
  localparam logic [6:0] H_LAST = 7'(IMG_WIDTH - 1);
  localparam logic [6:0] V_END  = 7'(IMG_HEIGHT);

  logic              vs_prev;
  logic              armed;
  logic [6:0]        in_h_cnt;
  logic [6:0]        in_v_cnt;
  logic [CW-1:0]     col0;
  logic [CW-1:0]     col1;
  logic [CW-1:0]     col2;
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];

  logic          rise;
  logic          acc;
  logic          take;
  logic          emit;
  logic [6:0]    h_cur;
  logic [6:0]    v_cur;
  logic [AW-1:0] idx;
  logic [CW-1:0] col_new;

  // A pixel on the vsync-rise cycle lands at (0,0) of the new frame.
  assign rise    = pix_vsync & ~vs_prev;
  assign h_cur   = rise ? 7'd0 : in_h_cnt;
  assign v_cur   = rise ? 7'd0 : in_v_cnt;
  assign acc     = armed & pix_vsync & pix_href;
  assign take    = acc & (v_cur != V_END);
  assign emit    = take & (v_cur >= 7'd2) & (h_cur >= 7'd2);
  assign idx     = h_cur[AW-1:0];
  assign col_new = {lb2[idx], lb1[idx], pix_data};

  // Columns are {top, mid, bottom}; output is row-major, left to right.
  function automatic logic [9*DATA_W-1:0] pack(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b,
    input logic [CW-1:0] c
  );
    logic [9*DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r[(2-k)*CW +: CW] = {a[(2-k)*DATA_W +: DATA_W],
                           b[(2-k)*DATA_W +: DATA_W],
                           c[(2-k)*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // Held high so a vsync already high at reset release is no frame start.
      vs_prev      <= 1'b1;
      armed        <= 1'b0;
      in_h_cnt     <= '0;
      in_v_cnt     <= '0;
      col0         <= '0;
      col1         <= '0;
      col2         <= '0;
      matrix_vsync <= 1'b0;
      matrix_href  <= 1'b0;
      matrix_h_cnt <= '0;
      matrix_v_cnt <= '0;
      fm_data      <= '0;
      frame_err    <= 1'b0;
    end else begin
      vs_prev      <= pix_vsync;
      matrix_vsync <= pix_vsync;
      if (rise) begin
        armed     <= 1'b1;
        in_h_cnt  <= '0;
        in_v_cnt  <= '0;
        frame_err <= 1'b0;
      end
      if (acc && !take) begin
        frame_err <= 1'b1;
      end
      if (take) begin
        col0 <= col1;
        col1 <= col2;
        col2 <= col_new;
        if (h_cur == H_LAST) begin
          in_h_cnt <= '0;
          in_v_cnt <= v_cur + 7'd1;
        end else begin
          in_h_cnt <= h_cur + 7'd1;
          in_v_cnt <= v_cur;
        end
      end
      matrix_href <= emit;
      if (emit) begin
        fm_data      <= pack(col1, col2, col_new);
        matrix_h_cnt <= h_cur - 7'd2;
        matrix_v_cnt <= v_cur - 7'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && !rst) begin
      lb2[idx] <= lb1[idx];
      lb1[idx] <= pix_data;
    end
  end
endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3: windows are cut from a
// per-frame image array and matched against DUT strobes.
module tb_conv_window_3x3;
  localparam int W  = 10;
  localparam int H  = 10;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            pv;
  logic            ph;
  logic [DW-1:0]   pd;
  logic            matrix_vsync;
  logic            matrix_href;
  logic [6:0]      matrix_h_cnt;
  logic [6:0]      matrix_v_cnt;
  logic [9*DW-1:0] fm_data;
  logic            frame_err;

  conv_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .pix_vsync(pv),
    .pix_href(ph),
    .pix_data(pd),
    .matrix_vsync(matrix_vsync),
    .matrix_href(matrix_href),
    .matrix_h_cnt(matrix_h_cnt),
    .matrix_v_cnt(matrix_v_cnt),
    .fm_data(fm_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    int              h;
    int              v;
    logic [9*DW-1:0] d;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] img [H][W];
  int            cyc = 0;
  int            strobes = 0;
  int            checks = 0;
  int            failures = 0;
  logic          exp_mvs = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    exp_mvs <= rst ? 1'b0 : pv;
  end

  task automatic chk(input string name,
                     input logic [9*DW-1:0] act,
                     input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("matrix_vsync", 144'(matrix_vsync), 144'(exp_mvs));
    if (matrix_href === 1'b1) begin
      strobes++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_strobe: got h=%0d v=%0d expected none",
                 matrix_h_cnt, matrix_v_cnt);
      end else begin
        e = q.pop_front();
        chk("latency", 144'(cyc), 144'(e.cyc));
        chk("h_cnt", 144'(matrix_h_cnt), 144'(e.h));
        chk("v_cnt", 144'(matrix_v_cnt), 144'(e.v));
        chk("fm_data", fm_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] gen(input int mode, input int r,
                                        input int c);
    case (mode)
      0:       return 16'(r * 16 + c);
      1:       return 16'(-(r * 16 + c));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push_window(input int r, input int c);
    exp_t e;
    e.cyc = cyc + 1;
    e.h   = c - 2;
    e.v   = r - 2;
    e.d   = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        e.d = {e.d[8*DW-1:0], img[r-2+i][c-2+j]};
      end
    end
    q.push_back(e);
  endtask

  task automatic frame(input int lines, input int mode,
                       input int gap, input int rst_row);
    bit live;
    int pushed;
    int s0;
    live   = 1'b1;
    pushed = 0;
    pv = 1'b0;
    ph = 1'b0;
    tick();
    tick();
    pv = 1'b1;
    tick();
    chk("frame_err_clear", 144'(frame_err), 144'(0));
    s0 = strobes;
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == rst_row && c == 0) begin
          rst = 1'b1;
          ph  = 1'b0;
          tick();
          rst  = 1'b0;
          live = 1'b0;
        end
        pd = gen(mode, r, c);
        ph = 1'b1;
        if (r < H) img[r][c] = pd;
        if (live && r < H && r >= 2 && c >= 2) begin
          push_window(r, c);
          pushed++;
        end
        tick();
        ph = 1'b0;
        if (live && r == H && c == 0)
          chk("frame_err_set", 144'(frame_err), 144'(1));
        if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
          tick();
      end
    end
    ph = 1'b0;
    tick();
    tick();
    chk("strobe_count", 144'(strobes - s0), 144'(pushed));
  endtask

  initial begin
    rst = 1'b1;
    pv  = 1'b0;
    ph  = 1'b0;
    pd  = '0;
    tick();
    tick();
    chk("rst_href", 144'(matrix_href), 144'(0));
    chk("rst_h_cnt", 144'(matrix_h_cnt), 144'(0));
    chk("rst_v_cnt", 144'(matrix_v_cnt), 144'(0));
    chk("rst_fm_data", fm_data, 144'(0));
    chk("rst_frame_err", 144'(frame_err), 144'(0));
    rst = 1'b0;
    frame(10, 0, 0, -1);
    frame(10, 0, 1, -1);
    frame(10, 1, 0, -1);
    frame(10, 0, 0, 5);
    frame(10, 2, 0, -1);
    chk("frame_err_after_rst", 144'(frame_err), 144'(0));
    frame(11, 0, 0, -1);
    chk("frame_err_sticky", 144'(frame_err), 144'(1));
    for (int k = 0; k < 3; k++) frame(10, 2, 2, -1);
    chk("frame_err_final", 144'(frame_err), 144'(0));
    pv = 1'b0;
    ph = 1'b0;
    repeat (4) tick();
    chk("queue_drained", 144'(q.size()), 144'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
